// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: receives framed packets from a UART receiver and writes
// the payload to memory. A frame is HDR, ADDR, LEN, LEN payload bytes and
// CHK, where CHK is the XOR of ADDR, LEN and the payload. It replies with
// ACK or NAK through the UART transmitter. Frames that stall between bytes
// for TIMEOUT_CYC cycles are rejected.
module uart_frame_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd52000,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RxData,
  input  logic       RxDone,
  input  logic       TxDone,
  output logic [7:0] TxData,
  output logic       TxEn,
  output logic       MemWe,
  output logic [7:0] MemAddr,
  output logic [7:0] MemWData,
  output logic       FrameOk,
  output logic       FrameErr,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    SEND,
    WAIT_TX
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic        rxDoneQ;
  logic        rxDonePrev;
  logic        txDoneQ;
  logic        txDonePrev;
  logic [7:0]  rxByte;
  logic        byteEdge;
  logic        txEdge;
  logic        inFrame;
  logic        timeout;
  logic [15:0] timer;
  logic [7:0]  baseAddr;
  logic [7:0]  chkSum;
  logic [7:0]  remCount;
  logic [7:0]  index;
  logic        ackSel;
  logic        memWeNext;
  logic        frameOkNext;
  logic        frameErrNext;

  assign byteEdge = rxDoneQ & ~rxDonePrev;
  assign txEdge   = txDoneQ & ~txDonePrev;
  assign inFrame  = (state == GET_ADDR) || (state == GET_LEN) ||
                    (state == GET_DATA) || (state == GET_CHK);
  assign timeout  = inFrame && (timer == TIMEOUT_CYC);

  // Register the UART flags and data so edges are detected independently of pulse width.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxDoneQ    <= 1'b0;
      rxDonePrev <= 1'b0;
      txDoneQ    <= 1'b0;
      txDonePrev <= 1'b0;
      rxByte     <= 8'h00;
    end else begin
      rxDoneQ    <= RxDone;
      rxDonePrev <= rxDoneQ;
      txDoneQ    <= TxDone;
      txDonePrev <= txDoneQ;
      rxByte     <= RxData;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; a byte edge always wins over a timeout in the same cycle.
  always_comb begin
    stateNext = state;
    ackSel    = 1'b0;
    case (state)
      IDLE: begin
        if (byteEdge && (rxByte == HDR_BYTE)) stateNext = GET_ADDR;
      end
      GET_ADDR: begin
        if (byteEdge)     stateNext = GET_LEN;
        else if (timeout) stateNext = SEND;
      end
      GET_LEN: begin
        if (byteEdge)     stateNext = (rxByte == 8'h00) ? SEND : GET_DATA;
        else if (timeout) stateNext = SEND;
      end
      GET_DATA: begin
        if (byteEdge) begin
          if (remCount == 8'd1) stateNext = GET_CHK;
        end else if (timeout) begin
          stateNext = SEND;
        end
      end
      GET_CHK: begin
        if (byteEdge) begin
          stateNext = SEND;
          ackSel    = (rxByte == chkSum);
        end else if (timeout) begin
          stateNext = SEND;
        end
      end
      SEND:    stateNext = WAIT_TX;
      WAIT_TX: begin
        if (txEdge) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: strobes that are registered next cycle plus direct state outputs.
  always_comb begin
    memWeNext    = (state == GET_DATA) && byteEdge;
    frameOkNext  = (state == GET_CHK) && byteEdge && (rxByte == chkSum);
    frameErrNext = ((state == GET_CHK) && byteEdge && (rxByte != chkSum)) ||
                   (!byteEdge && timeout);
    TxEn         = (state == SEND);
    Busy         = (state != IDLE);
  end

  // Frame datapath: timer, address/checksum/count tracking and registered strobes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      timer    <= 16'd0;
      baseAddr <= 8'h00;
      chkSum   <= 8'h00;
      remCount <= 8'h00;
      index    <= 8'h00;
      TxData   <= 8'h00;
      MemWe    <= 1'b0;
      MemAddr  <= 8'h00;
      MemWData <= 8'h00;
      FrameOk  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      MemWe    <= memWeNext;
      FrameOk  <= frameOkNext;
      FrameErr <= frameErrNext;
      if (inFrame && !byteEdge) timer <= timer + 16'd1;
      else                      timer <= 16'd0;
      if (byteEdge) begin
        case (state)
          GET_ADDR: begin
            baseAddr <= rxByte;
            chkSum   <= rxByte;
            index    <= 8'h00;
          end
          GET_LEN: begin
            chkSum   <= chkSum ^ rxByte;
            remCount <= rxByte;
          end
          GET_DATA: begin
            chkSum   <= chkSum ^ rxByte;
            remCount <= remCount - 8'd1;
            index    <= index + 8'd1;
            MemAddr  <= baseAddr + index;
            MemWData <= rxByte;
          end
          default: ;
        endcase
      end
      if ((state != SEND) && (stateNext == SEND)) begin
        TxData <= ackSel ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl. A monitor records writes,
// strobes and the transmitted byte; each test task checks those records.
module tb_uart_frame_ctrl;

  localparam logic [15:0] TMO = 16'd40;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] RxData = 8'h00;
  logic       RxDone = 1'b0;
  logic       TxDone = 1'b0;
  logic [7:0] TxData;
  logic       TxEn;
  logic       MemWe;
  logic [7:0] MemAddr;
  logic [7:0] MemWData;
  logic       FrameOk;
  logic       FrameErr;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] wrAddr[$];
  logic [7:0] wrData[$];
  int         nOk;
  int         nErr;
  int         nTxEn;
  logic [7:0] txAtEn;

  uart_frame_ctrl #(
    .TIMEOUT_CYC(TMO),
    .HDR_BYTE(8'hA5),
    .ACK_BYTE(8'h06),
    .NAK_BYTE(8'h15)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .RxData(RxData),
    .RxDone(RxDone),
    .TxDone(TxDone),
    .TxData(TxData),
    .TxEn(TxEn),
    .MemWe(MemWe),
    .MemAddr(MemAddr),
    .MemWData(MemWData),
    .FrameOk(FrameOk),
    .FrameErr(FrameErr),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Record DUT activity on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (MemWe) begin
        wrAddr.push_back(MemAddr);
        wrData.push_back(MemWData);
      end
      if (FrameOk)  nOk++;
      if (FrameErr) nErr++;
      if (TxEn) begin
        nTxEn++;
        txAtEn = TxData;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic clearMon();
    wrAddr.delete();
    wrData.delete();
    nOk = 0;
    nErr = 0;
    nTxEn = 0;
    txAtEn = 8'hxx;
  endtask

  task automatic sendByte(input logic [7:0] b);
    RxData = b;
    RxDone = 1'b1;
    tick(3);
    RxDone = 1'b0;
    tick(3);
  endtask

  task automatic sendFrame(input logic [7:0] b[8], input int n);
    for (int i = 0; i < n; i++) sendByte(b[i]);
  endtask

  task automatic pulseTxDone();
    TxDone = 1'b1;
    tick(2);
    TxDone = 1'b0;
    tick(3);
  endtask

  function automatic logic [7:0] xorBytes(input logic [7:0] b[8], input int first, input int n);
    logic [7:0] x = 8'h00;
    for (int i = first; i < first + n; i++) x = x ^ b[i];
    return x;
  endfunction

  task automatic test_reset();
    tick(1);
    checks++;
    if ({TxEn, MemWe, FrameOk, FrameErr, Busy} !== 5'b0 ||
        TxData !== 8'h00 || MemAddr !== 8'h00 || MemWData !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got En/We/Ok/Err/Busy=%b Tx=%h Addr=%h WData=%h required all zero",
               {TxEn, MemWe, FrameOk, FrameErr, Busy}, TxData, MemAddr, MemWData);
    end
    Rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_frame(input string name, input logic [7:0] addr, input logic [7:0] chkDelta,
                            input logic [7:0] expTx, input int expOk);
    logic [7:0] f[8];
    logic [7:0] expA[3];
    f = '{8'hA5, addr, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    f[6] = xorBytes(f, 1, 5) ^ chkDelta;
    for (int i = 0; i < 3; i++) expA[i] = addr + 8'(i);
    clearMon();
    sendFrame(f, 7);
    checks++;
    if (wrAddr.size() != 3) begin
      errors++;
      $display("[TB] FAIL %s_write_count: got %0d required 3", name, wrAddr.size());
    end
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== expA[i] || wrData[i] !== f[3+i]) begin
        errors++;
        $display("[TB] FAIL %s_write%0d: got %h=%h required %h=%h", name, i, wrAddr[i], wrData[i], expA[i], f[3+i]);
      end
    end
    checks++;
    if (nOk !== expOk || nErr !== 1 - expOk) begin
      errors++;
      $display("[TB] FAIL %s_status: got ok=%0d err=%0d required ok=%0d err=%0d", name, nOk, nErr, expOk, 1 - expOk);
    end
    checks++;
    if (nTxEn !== 1 || txAtEn !== expTx) begin
      errors++;
      $display("[TB] FAIL %s_tx: got en=%0d byte=%h required en=1 byte=%h", name, nTxEn, txAtEn, expTx);
    end
    checks++;
    if (Busy !== 1'b1 || TxData !== expTx) begin
      errors++;
      $display("[TB] FAIL %s_hold: got busy=%b tx=%h required busy=1 tx=%h", name, Busy, TxData, expTx);
    end
    pulseTxDone();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle: got busy=%b required 0", name, Busy);
    end
  endtask

  task automatic test_len_zero();
    clearMon();
    sendByte(8'h00);
    sendByte(8'hFF);
    checks++;
    if (Busy !== 1'b0 || nTxEn !== 0 || wrAddr.size() != 0) begin
      errors++;
      $display("[TB] FAIL garbage_ignored: got busy=%b en=%0d writes=%0d required 0 0 0", Busy, nTxEn, wrAddr.size());
    end
    sendByte(8'hA5);
    sendByte(8'h05);
    sendByte(8'h00);
    checks++;
    if (nTxEn !== 1 || txAtEn !== 8'h15 || wrAddr.size() != 0 || nOk !== 0) begin
      errors++;
      $display("[TB] FAIL len_zero: got en=%0d tx=%h writes=%0d ok=%0d required 1 15 0 0",
               nTxEn, txAtEn, wrAddr.size(), nOk);
    end
    pulseTxDone();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_zero_idle: got busy=%b required 0", Busy);
    end
  endtask

  task automatic test_timeout();
    int waited = 0;
    clearMon();
    sendByte(8'hA5);
    sendByte(8'h20);
    sendByte(8'h02);
    sendByte(8'h11);
    checks++;
    if (nTxEn !== 0 || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_early: got en=%0d busy=%b required 0 1", nTxEn, Busy);
    end
    while (nTxEn == 0 && waited < 200) begin
      tick(1);
      waited++;
    end
    tick(2);
    checks++;
    if (nTxEn !== 1 || txAtEn !== 8'h15 || nErr !== 1 || nOk !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_nak: got en=%0d tx=%h err=%0d ok=%0d required 1 15 1 0", nTxEn, txAtEn, nErr, nOk);
    end
    checks++;
    if (wrAddr.size() != 1 || (wrAddr.size() == 1 && (wrAddr[0] !== 8'h20 || wrData[0] !== 8'h11))) begin
      errors++;
      $display("[TB] FAIL timeout_writes: got count=%0d required one write 20=11", wrAddr.size());
    end
    pulseTxDone();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got busy=%b required 0", Busy);
    end
  endtask

  task automatic test_reset_mid_payload();
    clearMon();
    sendByte(8'hA5);
    sendByte(8'h40);
    sendByte(8'h03);
    sendByte(8'hAA);
    checks++;
    if (Busy !== 1'b1 || MemAddr !== 8'h40 || MemWData !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL mid_payload: got busy=%b addr=%h wdata=%h required 1 40 AA", Busy, MemAddr, MemWData);
    end
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({TxEn, MemWe, FrameOk, FrameErr, Busy} !== 5'b0 ||
        TxData !== 8'h00 || MemAddr !== 8'h00 || MemWData !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got En/We/Ok/Err/Busy=%b Tx=%h Addr=%h WData=%h required all zero",
               {TxEn, MemWe, FrameOk, FrameErr, Busy}, TxData, MemAddr, MemWData);
    end
    tick(2);
    Rst_n = 1'b1;
    tick(2);
    clearMon();
    sendByte(8'hBB);
    sendByte(8'hCC);
    checks++;
    if (wrAddr.size() != 0 || nOk !== 0 || nErr !== 0 || nTxEn !== 0 || Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset: got writes=%0d ok=%0d err=%0d en=%0d busy=%b required all zero",
               wrAddr.size(), nOk, nErr, nTxEn, Busy);
    end
  endtask

  task automatic test_hdr_in_wait_tx();
    clearMon();
    sendByte(8'hA5);
    sendByte(8'h30);
    sendByte(8'h01);
    sendByte(8'h77);
    sendByte(8'h30 ^ 8'h01 ^ 8'h77);
    sendByte(8'hA5);
    pulseTxDone();
    checks++;
    if (Busy !== 1'b0 || nTxEn !== 1 || txAtEn !== 8'h06) begin
      errors++;
      $display("[TB] FAIL wait_tx_hdr: got busy=%b en=%0d tx=%h required 0 1 06", Busy, nTxEn, txAtEn);
    end
    sendByte(8'h10);
    sendByte(8'h01);
    sendByte(8'h55);
    sendByte(8'h10 ^ 8'h01 ^ 8'h55);
    checks++;
    if (wrAddr.size() != 1 || Busy !== 1'b0 || nTxEn !== 1 || nOk !== 1) begin
      errors++;
      $display("[TB] FAIL hdr_dropped: got writes=%0d busy=%b en=%0d ok=%0d required 1 0 1 1",
               wrAddr.size(), Busy, nTxEn, nOk);
    end
  endtask

  initial begin
    clearMon();
    test_reset();
    test_frame("good_frame", 8'h10, 8'h00, 8'h06, 1);
    test_frame("bad_chk", 8'h10, 8'h13 ^ 8'h12, 8'h15, 0);
    test_frame("addr_wrap", 8'hFE, 8'h00, 8'h06, 1);
    test_len_zero();
    test_timeout();
    test_reset_mid_payload();
    test_hdr_in_wait_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
